// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges always-accepted pipeline writebacks with
// queued long-latency writes, killing queued writes made stale by younger primaries.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_we,
  input  logic [4:0]        p_wa,
  input  logic [DATA_W-1:0] p_wd,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [4:0]        s_wa,
  input  logic [DATA_W-1:0] s_wd,
  output logic              we3,
  output logic [4:0]        wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [4:0]        addr_q [DEPTH];
  logic [4:0]        addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we3_q, we3_d;
  logic [4:0]        wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;

  logic p_act, s_hs, s_push, head_valid, head_live, pop;

  // Handshake and pop decisions; s_ready depends only on registered occupancy.
  assign s_ready    = (cnt_q < CNT_W'(DEPTH));
  assign busy       = (cnt_q != '0);
  assign p_act      = p_we && (p_wa != 5'd0);
  assign s_hs       = s_valid && s_ready;
  assign s_push     = s_hs && (s_wa != 5'd0) && !(p_act && (p_wa == s_wa));
  assign head_valid = (cnt_q != '0);
  assign head_live  = head_valid && live_q[rd_ptr_q];
  assign pop        = head_valid && (!head_live || !p_act);

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;

    // A primary write is younger than anything queued, so same-address entries die.
    for (int i = 0; i < DEPTH; i++) begin
      if (p_act && (addr_q[i] == p_wa)) live_d[i] = 1'b0;
    end

    if (s_push) begin
      addr_d[wr_ptr_q] = s_wa;
      data_d[wr_ptr_q] = s_wd;
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (p_act) begin
      we3_d = 1'b1;
      wa3_d = p_wa;
      wd3_d = p_wd;
    end else if (head_live) begin
      we3_d = 1'b1;
      wa3_d = addr_q[rd_ptr_q];
      wd3_d = data_q[rd_ptr_q];
    end

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end

    cnt_d = cnt_q + CNT_W'(s_push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;

endmodule
